// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard sequencer - load-use bubbles, memory-wait freeze,
// branch flushes and a watchdog that aborts memory accesses that never acknowledge.
module hazard_ctrl #(
    parameter int CNT_W    = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_is_load_i,
    input  logic       mem_req_i,
    input  logic       mem_ack_i,
    input  logic       mem_err_i,
    input  logic       branch_taken_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       stall_ex_o,
    output logic       stall_mem_o,
    output logic       bubble_ex_o,
    output logic       bubble_wb_o,
    output logic       flush_id_o,
    output logic       flush_ex_o,
    output logic       flush_mem_o,
    output logic       mem_fault_o
);
    typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             lu, mwait, merr;

    assign lu = ex_is_load_i && ex_rd_i != 5'd0 &&
                ((id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i));
    assign mwait   = mem_req_i & ~mem_ack_i & ~mem_err_i;
    assign merr    = mem_req_i & mem_err_i;
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx    = RUN;
        cnt_nx      = '0;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        bubble_ex_o = 1'b0;
        bubble_wb_o = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        flush_mem_o = 1'b0;
        mem_fault_o = 1'b0;
        if (!rst_i) begin
            if (state == FAULT) begin
                mem_fault_o = 1'b1;
                flush_id_o  = 1'b1;
                flush_ex_o  = 1'b1;
                flush_mem_o = 1'b1;
                bubble_wb_o = 1'b1;
            end else if (mwait || merr) begin
                // a memory stall masks load-use and branch until the pipe moves again
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                stall_mem_o = 1'b1;
                bubble_wb_o = 1'b1;
                cnt_nx      = mwait ? cnt_inc : '0;
                state_nx    = (merr || cnt_inc == CNT_W'(MAX_WAIT)) ? FAULT : WAIT;
            end else if (lu) begin
                stall_if_o  = 1'b1;
                stall_id_o  = 1'b1;
                bubble_ex_o = 1'b1;
            end else if (branch_taken_i) begin
                flush_id_o  = 1'b1;
                flush_ex_o  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random traffic checked against a
// cycle-level reference model of the hazard rules (MAX_WAIT=4).
module tb_hazard_ctrl;
    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic       id_use_rs1_i, id_use_rs2_i, ex_is_load_i;
    logic       mem_req_i, mem_ack_i, mem_err_i, branch_taken_i;
    logic       stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic       bubble_ex_o, bubble_wb_o, flush_id_o, flush_ex_o, flush_mem_o, mem_fault_o;

    int total = 0;
    int bad = 0;
    int wait_run = 0;
    bit fault_due = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(8), .MAX_WAIT(MAXW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
        .branch_taken_i(branch_taken_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
        .stall_mem_o(stall_mem_o), .bubble_ex_o(bubble_ex_o), .bubble_wb_o(bubble_wb_o),
        .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o), .flush_mem_o(flush_mem_o),
        .mem_fault_o(mem_fault_o)
    );

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // bit order: stall if/id/ex/mem, bubble ex/wb, flush id/ex/mem, fault
    function automatic logic [9:0] expected();
        bit hz, waiting, err;
        hz = ex_is_load_i && ex_rd_i != 0 &&
             ((id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i));
        waiting = mem_req_i && !mem_ack_i && !mem_err_i;
        err = mem_req_i && mem_err_i;
        if (rst_i) return 10'b0;
        if (fault_due) return 10'b0000_01_111_1;
        if (waiting || err) return 10'b1111_01_000_0;
        if (hz) return 10'b1100_10_000_0;
        if (branch_taken_i) return 10'b0000_00_110_0;
        return 10'b0;
    endfunction

    task automatic cyc(input string tag, input bit rst, input bit ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                       input bit req, input bit ack, input bit err, input bit br);
        @(negedge clk);
        rst_i = rst; ex_is_load_i = ld; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        id_use_rs1_i = u1; id_use_rs2_i = u2;
        mem_req_i = req; mem_ack_i = ack; mem_err_i = err; branch_taken_i = br;
        #1;
        check(tag, {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, bubble_ex_o, bubble_wb_o,
                    flush_id_o, flush_ex_o, flush_mem_o, mem_fault_o}, expected());
        @(posedge clk);
        if (rst) begin
            wait_run = 0; fault_due = 1'b0;
        end else if (fault_due) begin
            wait_run = 0; fault_due = 1'b0;
        end else if (req && !ack && !err) begin
            wait_run++;
            fault_due = (wait_run == MAXW);
        end else begin
            fault_due = req && err;
            wait_run = 0;
        end
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc("reset0", 1, 1, 5, 5, 5, 1, 1, 1, 0, 0, 1);
        cyc("reset1", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        idle("idle");
        // load-use on rs2, then rd=x0
        cyc("lu_rs2", 0, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0);
        idle("lu_after");
        cyc("lu_x0", 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // acked after 3 wait cycles
        repeat (3) cyc("wait3", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("ack3", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle("after_ack");
        // never acked: 4 stall cycles, fault, back to run
        repeat (4) cyc("wd_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("wd_fault", 0, 1, 5, 5, 5, 1, 1, 1, 0, 0, 1);
        idle("wd_run");
        // branch held through a 2-cycle wait
        repeat (2) cyc("br_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc("br_ack", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        idle("br_done");
        // bus error on the 2nd request cycle
        cyc("err_w", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("err_c", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        cyc("err_f", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle("err_run");
        // reset in the 2nd wait cycle, then a fresh request counts from 1
        cyc("rw_w1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("rw_rst", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (4) cyc("rw_w", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc("rw_f", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle("rw_run");
        for (int i = 0; i < 2000; i++) begin
            cyc("rand", $urandom_range(0, 60) == 0, 1'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 15) == 0, 1'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
